// File: rtl/event_pulse_train.sv
// ----------------------------------------------------------------------------
// event_pulse_train
//
// Turns a single trigger strobe into a timed burst of pulses. A trigger taken
// in IDLE latches the burst configuration. The block then waits cfg_delay
// cycles and drives cfg_count pulses, each cfg_high cycles high, separated by
// cfg_low cycles low. Because the configuration is captured when the trigger
// is accepted, a burst already running ignores later configuration changes.
//
// Parameters
//   CNT_W      width of every configuration field, internal counter and
//              pulse_num
//
// Ports
//   clk        system clock, all logic on the rising edge
//   rst        synchronous reset, active high (highest priority)
//   ena        clock enable; low freezes state, counters and outputs
//   trig       start strobe, only accepted in IDLE while ena=1
//   abort      synchronous burst cancel, works regardless of ena
//   cfg_delay  cycles from accepted trig to first pulse rise (0 allowed)
//   cfg_high   high width per pulse in cycles (0 behaves as 1)
//   cfg_low    low gap between pulses in cycles (0 behaves as 1)
//   cfg_count  pulses per burst (0 gives an empty burst: done only)
//   out        registered pulse train
//   busy       high from the cycle after an accepted trig until burst end
//   done       one-cycle strobe on normal burst completion (never on abort)
//   pulse_num  0-based index of the current pulse, held after the burst
// ----------------------------------------------------------------------------
module event_pulse_train #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             trig,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_low,
    input  logic [CNT_W-1:0] cfg_count,
    output logic             out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulse_num
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ZERO = '0;
    localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;

    // One shared down-counter serves every timed phase. It is loaded with
    // (length - 1) and the phase ends on the cycle it reads zero, so a full
    // width value of 2^CNT_W-1 still fits without an extra counter bit.
    logic [CNT_W-1:0] cnt;

    // Burst configuration captured on the accepted trigger, already reduced
    // to the "minus one" form the counter expects.
    logic [CNT_W-1:0] high_m1;
    logic [CNT_W-1:0] low_m1;
    logic [CNT_W-1:0] last_idx;

    // Widths of 0 are treated as 1, so both map to a reload value of 0.
    logic [CNT_W-1:0] cfg_high_m1;
    logic [CNT_W-1:0] cfg_low_m1;

    // NOTE: every signal driven from always_comb gets a value on every path
    // (here through the conditional operator); a missing branch would infer
    // a latch.
    always_comb begin
        cfg_high_m1 = (cfg_high == ZERO) ? ZERO : (cfg_high - ONE);
        cfg_low_m1  = (cfg_low  == ZERO) ? ZERO : (cfg_low  - ONE);
    end

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= ZERO;
            high_m1   <= ZERO;
            low_m1    <= ZERO;
            last_idx  <= ZERO;
            out       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pulse_num <= ZERO;
        end else if (abort) begin
            // Cancel is not gated by ena; pulse_num keeps the aborted index
            // and no completion strobe is produced.
            state <= ST_IDLE;
            out   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (ena) begin
            // done is a strobe: cleared on every enabled edge unless the
            // branch below raises it again.
            done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (trig) begin
                        high_m1   <= cfg_high_m1;
                        low_m1    <= cfg_low_m1;
                        last_idx  <= cfg_count - ONE;
                        pulse_num <= ZERO;
                        if (cfg_count == ZERO) begin
                            // Empty burst: completes immediately, never busy.
                            done <= 1'b1;
                        end else if (cfg_delay == ZERO) begin
                            state <= ST_HIGH;
                            out   <= 1'b1;
                            busy  <= 1'b1;
                            cnt   <= cfg_high_m1;
                        end else begin
                            state <= ST_DELAY;
                            busy  <= 1'b1;
                            cnt   <= cfg_delay - ONE;
                        end
                    end
                end

                ST_DELAY: begin
                    if (cnt == ZERO) begin
                        state <= ST_HIGH;
                        out   <= 1'b1;
                        cnt   <= high_m1;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end

                ST_HIGH: begin
                    if (cnt == ZERO) begin
                        out <= 1'b0;
                        if (pulse_num == last_idx) begin
                            // Last pulse ends: back to IDLE on the same edge,
                            // so a new trigger is accepted during done.
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_LOW;
                            cnt   <= low_m1;
                        end
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end

                ST_LOW: begin
                    if (cnt == ZERO) begin
                        state     <= ST_HIGH;
                        out       <= 1'b1;
                        cnt       <= high_m1;
                        pulse_num <= pulse_num + ONE;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    out   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
